// File: rtl/perf_pkg.sv
// Shared constants for the performance counter bank: CSR map, inhibit bit layout,
// counter index enum and small elaboration-time helpers.
package perf_pkg;

   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MHPM3         = 12'hB03;
   localparam logic [11:0] CSR_HI_OFFSET     = 12'h080;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_OVF_STATUS    = 12'h7C0;
   localparam logic [11:0] CSR_OVF_ENABLE    = 12'h7C1;

   localparam int INH_CYCLE    = 0;
   localparam int INH_INSTRET  = 2;
   localparam int INH_HPM_BASE = 3;

   typedef enum logic [4:0] {
      CNT_CYCLE    = 5'd0,
      CNT_INSTRET  = 5'd1,
      CNT_HPM_BASE = 5'd2
   } cnt_idx_e;

   // Counters are stored densely; CSR numbering leaves a hole at 0xB01 (time).
   function automatic logic [11:0] cnt_lo_addr(int idx);
      if (idx == int'(CNT_CYCLE))   return CSR_MCYCLE;
      if (idx == int'(CNT_INSTRET)) return CSR_MINSTRET;
      return CSR_MHPM3 + 12'(idx - int'(CNT_HPM_BASE));
   endfunction

   function automatic int inh_bit(int idx);
      if (idx == int'(CNT_CYCLE))   return INH_CYCLE;
      if (idx == int'(CNT_INSTRET)) return INH_INSTRET;
      return INH_HPM_BASE + idx - int'(CNT_HPM_BASE);
   endfunction

   function automatic logic [31:0] impl_mask(int num_hpm);
      logic [31:0] m;
      m = '0;
      m[INH_CYCLE]   = 1'b1;
      m[INH_INSTRET] = 1'b1;
      for (int k = 0; k < num_hpm; k++) m[INH_HPM_BASE + k] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One performance counter: increments when enabled, accepts split lo/hi CSR writes
// (a write beats the increment) and pulses wrap_o on an all-ones rollover.
module perf_counter_cell #(
   parameter int CNT_WIDTH = 64,
   parameter int XLEN      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc_i,
   input  logic                 inhibit_i,
   input  logic                 we_lo_i,
   input  logic                 we_hi_i,
   input  logic [XLEN-1:0]      wdata_i,
   output logic [CNT_WIDTH-1:0] count_o,
   output logic                 wrap_o
);

   localparam int HIW = CNT_WIDTH - XLEN;

   logic [CNT_WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      wrap_o  = 1'b0;
      if (we_lo_i) begin
         count_d[XLEN-1:0] = wdata_i;
      end else if (we_hi_i) begin
         count_d[CNT_WIDTH-1:XLEN] = wdata_i[HIW-1:0];
      end else if (inc_i && !inhibit_i) begin
         count_d = count_q + 1'b1;
         wrap_o  = &count_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) count_q <= '0;
      else      count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/perf_counter_bank.sv
// mcycle/minstret/mhpmcounter bank with inhibit mask and registered CSR read port.
// Define PERF_OVF_IRQ_EN to add the overflow status/enable CSRs and the ovf_irq output.
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int NUM_HPM   = 4,
   parameter int CNT_WIDTH = 64,
   parameter int XLEN      = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instret_en,
   input  logic [NUM_HPM-1:0] event_i,
   input  logic               csr_re,
   input  logic               csr_we,
   input  logic [11:0]        csr_addr,
   input  logic [XLEN-1:0]    csr_wdata,
   output logic               csr_rvalid,
   output logic [XLEN-1:0]    csr_rdata,
   output logic               csr_hit,
   output logic               ovf_irq
);

   localparam int NCNT = NUM_HPM + 2;
   localparam logic [XLEN-1:0] IMPL_MASK = XLEN'(impl_mask(NUM_HPM));

   logic [CNT_WIDTH-1:0] count [NCNT];
   logic [NCNT-1:0]      wrap;
   logic [NCNT-1:0]      we_lo, we_hi;
   logic                 we_inh;
   logic [XLEN-1:0]      inhibit_q, inhibit_d;
   logic [XLEN-1:0]      rdata_q, rdata_d;
   logic                 rvalid_q;

`ifdef PERF_OVF_IRQ_EN
   logic            we_ovf, we_en;
   logic [XLEN-1:0] ovf_q, ovf_d, ovf_en_q, ovf_en_d, wrap_bits;
   logic            ovf_irq_q;
`endif

   for (genvar g = 0; g < NCNT; g++) begin : g_cell
      logic src;
      if (g == int'(CNT_CYCLE)) begin : g_src_cycle
         assign src = 1'b1;
      end else if (g == int'(CNT_INSTRET)) begin : g_src_instret
         assign src = instret_en;
      end else begin : g_src_hpm
         assign src = event_i[g - int'(CNT_HPM_BASE)];
      end

      perf_counter_cell #(
         .CNT_WIDTH (CNT_WIDTH),
         .XLEN      (XLEN)
      ) u_cell (
         .clk       (clk),
         .rst       (rst),
         .inc_i     (src),
         .inhibit_i (inhibit_q[inh_bit(g)]),
         .we_lo_i   (we_lo[g]),
         .we_hi_i   (we_hi[g]),
         .wdata_i   (csr_wdata),
         .count_o   (count[g]),
         .wrap_o    (wrap[g])
      );
   end

   // Address decode, write strobes and the read mux share one pass over the map.
   always_comb begin
      csr_hit = 1'b0;
      rdata_d = '0;
      we_lo   = '0;
      we_hi   = '0;
      we_inh  = 1'b0;
`ifdef PERF_OVF_IRQ_EN
      we_ovf  = 1'b0;
      we_en   = 1'b0;
`endif
      if (csr_addr == CSR_MCOUNTINHIBIT) begin
         csr_hit = 1'b1;
         rdata_d = inhibit_q;
         we_inh  = csr_we;
      end
      for (int i = 0; i < NCNT; i++) begin
         if (csr_addr == cnt_lo_addr(i)) begin
            csr_hit  = 1'b1;
            rdata_d  = count[i][XLEN-1:0];
            we_lo[i] = csr_we;
         end
         if (csr_addr == cnt_lo_addr(i) + CSR_HI_OFFSET) begin
            csr_hit  = 1'b1;
            rdata_d  = XLEN'(count[i][CNT_WIDTH-1:XLEN]);
            we_hi[i] = csr_we;
         end
      end
`ifdef PERF_OVF_IRQ_EN
      if (csr_addr == CSR_OVF_STATUS) begin
         csr_hit = 1'b1;
         rdata_d = ovf_q;
         we_ovf  = csr_we;
      end
      if (csr_addr == CSR_OVF_ENABLE) begin
         csr_hit = 1'b1;
         rdata_d = ovf_en_q;
         we_en   = csr_we;
      end
`endif
   end

   assign inhibit_d = we_inh ? (csr_wdata & IMPL_MASK) : inhibit_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inhibit_q <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         inhibit_q <= inhibit_d;
         rvalid_q  <= csr_re;
         if (csr_re) rdata_q <= rdata_d;
      end
   end

   assign csr_rvalid = rvalid_q;
   assign csr_rdata  = rdata_q;

`ifdef PERF_OVF_IRQ_EN
   // A wrap landing in the same cycle as a clearing write must survive it.
   always_comb begin
      wrap_bits = '0;
      for (int i = 0; i < NCNT; i++) wrap_bits[inh_bit(i)] = wrap[i];
      ovf_d = ovf_q;
      if (we_ovf) ovf_d = ovf_q & ~csr_wdata;
      ovf_d    = (ovf_d | wrap_bits) & IMPL_MASK;
      ovf_en_d = we_en ? (csr_wdata & IMPL_MASK) : ovf_en_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q     <= '0;
         ovf_en_q  <= '0;
         ovf_irq_q <= 1'b0;
      end else begin
         ovf_q     <= ovf_d;
         ovf_en_q  <= ovf_en_d;
         ovf_irq_q <= |(ovf_d & ovf_en_d);
      end
   end

   assign ovf_irq = ovf_irq_q;
`else
   logic unused_wrap;
   assign unused_wrap = ^wrap;
   assign ovf_irq     = 1'b0;
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomised and directed bench for perf_counter_bank against a CSR-number-indexed model.
module tb_perf_counter_bank;

   localparam int NUM_HPM = 4;

   logic               clk;
   logic               rst;
   logic               instret_en;
   logic [NUM_HPM-1:0] event_i;
   logic               csr_re;
   logic               csr_we;
   logic [11:0]        csr_addr;
   logic [31:0]        csr_wdata;
   logic               csr_rvalid;
   logic [31:0]        csr_rdata;
   logic               csr_hit;
   logic               ovf_irq;

   perf_counter_bank #(
      .NUM_HPM   (NUM_HPM),
      .CNT_WIDTH (64),
      .XLEN      (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .instret_en (instret_en),
      .event_i    (event_i),
      .csr_re     (csr_re),
      .csr_we     (csr_we),
      .csr_addr   (csr_addr),
      .csr_wdata  (csr_wdata),
      .csr_rvalid (csr_rvalid),
      .csr_rdata  (csr_rdata),
      .csr_hit    (csr_hit),
      .ovf_irq    (ovf_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model indexed by CSR number low bits: 0 cycle, 2 instret, 3+k hpm(3+k).
   logic [63:0] cnt_m [32];
   logic [31:0] inh_m, ovf_m, en_m, impl_m;
   logic        irq_m;
   logic        exp_rvalid;
   logic [31:0] last_rdata;
   logic [31:0] exp_q [$];
   logic        hit_seen;

   function automatic logic model_is_cnt(logic [11:0] a);
      return (a[11:8] == 4'hB) && (a[6:5] == 2'b00) && impl_m[a[4:0]];
   endfunction

   function automatic logic model_hit(logic [11:0] a);
      logic h;
      h = (a == 12'h320) || model_is_cnt(a);
`ifdef PERF_OVF_IRQ_EN
      h = h || (a == 12'h7C0) || (a == 12'h7C1);
`endif
      return h;
   endfunction

   function automatic logic [31:0] model_read(logic [11:0] a);
      if (a == 12'h320) return inh_m;
      if (model_is_cnt(a)) return a[7] ? cnt_m[a[4:0]][63:32] : cnt_m[a[4:0]][31:0];
`ifdef PERF_OVF_IRQ_EN
      if (a == 12'h7C0) return ovf_m;
      if (a == 12'h7C1) return en_m;
`endif
      return 32'h0;
   endfunction

   task automatic model_reset();
      for (int n = 0; n < 32; n++) cnt_m[n] = 64'h0;
      inh_m      = 32'h0;
      ovf_m      = 32'h0;
      en_m       = 32'h0;
      irq_m      = 1'b0;
      exp_rvalid = 1'b0;
      last_rdata = 32'h0;
      exp_q.delete();
   endtask

   task automatic model_step(input logic re, input logic we, input logic [11:0] addr,
                             input logic [31:0] wd, input logic ir, input logic [NUM_HPM-1:0] ev);
      logic [31:0] wbits;
      logic        src;
      wbits = 32'h0;
      exp_rvalid = re;
      if (re) begin
         last_rdata = model_read(addr);
         exp_q.push_back(last_rdata);
      end
      for (int n = 0; n < 32; n++) begin
         if (impl_m[n]) begin
            if (n == 0) src = 1'b1;
            else if (n == 2) src = ir;
            else src = ev[n-3];
            if (we && addr == 12'hB00 + 12'(n)) cnt_m[n][31:0] = wd;
            else if (we && addr == 12'hB80 + 12'(n)) cnt_m[n][63:32] = wd;
            else if (src && !inh_m[n]) begin
               if (cnt_m[n] == 64'hFFFF_FFFF_FFFF_FFFF) wbits[n] = 1'b1;
               cnt_m[n] = cnt_m[n] + 64'd1;
            end
         end
      end
      if (we && addr == 12'h320) inh_m = wd & impl_m;
`ifdef PERF_OVF_IRQ_EN
      if (we && addr == 12'h7C0) ovf_m = ovf_m & ~wd;
      ovf_m = ovf_m | wbits;
      if (we && addr == 12'h7C1) en_m = wd & impl_m;
      irq_m = |(ovf_m & en_m);
`endif
   endtask

   // Called at a negedge; applies one cycle of stimulus and returns at the next negedge.
   task automatic drive(input logic re, input logic we, input logic [11:0] addr,
                        input logic [31:0] wd, input logic ir, input logic [NUM_HPM-1:0] ev);
      csr_re     = re;
      csr_we     = we;
      csr_addr   = addr;
      csr_wdata  = wd;
      instret_en = ir;
      event_i    = ev;
      #1 hit_seen = csr_hit;
      @(posedge clk);
      model_step(re, we, addr, wd, ir, ev);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, '0);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      csr_re = 1'b0; csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
      instret_en = 1'b0; event_i = '0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++; if (csr_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %0b want 0", csr_rvalid); end
      checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", csr_rdata); end
      checks++; if (ovf_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b want 0", ovf_irq); end
      rst = 1'b1;
   endtask

   task automatic test_mcycle();
      logic [31:0] e;
      idle(10);
      drive(1'b1, 1'b0, 12'hB00, 32'h0, 1'b0, '0);
      e = exp_q.pop_front();
      checks++; if (csr_rvalid !== 1'b1) begin errors++; $display("FAIL mcycle_rvalid: got %0b want 1", csr_rvalid); end
      checks++; if (csr_rdata !== e || e !== 32'd10) begin errors++; $display("FAIL mcycle_value: got %0d want %0d (10)", csr_rdata, e); end
      idle(1);
      checks++; if (csr_rvalid !== 1'b0) begin errors++; $display("FAIL mcycle_rvalid_drop: got %0b want 0", csr_rvalid); end
      checks++; if (csr_rdata !== e) begin errors++; $display("FAIL rdata_hold: got %h want %h", csr_rdata, e); end
   endtask

   task automatic test_instret_carry();
      logic [31:0] e;
      drive(1'b0, 1'b1, 12'hB02, 32'hFFFF_FFFF, 1'b0, '0);
      drive(1'b0, 1'b1, 12'hB82, 32'h0, 1'b0, '0);
      drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, '0);
      drive(1'b1, 1'b0, 12'hB02, 32'h0, 1'b0, '0);
      e = exp_q.pop_front();
      checks++; if (csr_rdata !== e || e !== 32'h0) begin errors++; $display("FAIL instret_lo: got %h want %h", csr_rdata, e); end
      drive(1'b1, 1'b0, 12'hB82, 32'h0, 1'b0, '0);
      e = exp_q.pop_front();
      checks++; if (csr_rdata !== e || e !== 32'h1) begin errors++; $display("FAIL instret_hi: got %h want %h", csr_rdata, e); end
   endtask

   task automatic test_inhibit();
      logic [31:0] e;
      drive(1'b0, 1'b1, 12'h320, 32'h8, 1'b0, '0);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 4'b0001);
      drive(1'b1, 1'b0, 12'hB03, 32'h0, 1'b0, '0);
      e = exp_q.pop_front();
      checks++; if (csr_rdata !== e || e !== 32'd0) begin errors++; $display("FAIL inhibit_hold: got %0d want %0d", csr_rdata, e); end
      drive(1'b1, 1'b0, 12'h320, 32'h0, 1'b0, '0);
      e = exp_q.pop_front();
      checks++; if (csr_rdata !== e || e !== 32'h8) begin errors++; $display("FAIL inhibit_read: got %h want %h", csr_rdata, e); end
      drive(1'b0, 1'b1, 12'h320, 32'h0, 1'b0, '0);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 4'b0001);
      drive(1'b1, 1'b0, 12'hB03, 32'h0, 1'b0, '0);
      e = exp_q.pop_front();
      checks++; if (csr_rdata !== e || e !== 32'd5) begin errors++; $display("FAIL inhibit_release: got %0d want %0d", csr_rdata, e); end
   endtask

   task automatic test_write_priority();
      logic [31:0] e;
      drive(1'b1, 1'b1, 12'hB03, 32'd7, 1'b0, 4'b0001);
      e = exp_q.pop_front();
      checks++; if (csr_rdata !== e || e !== 32'd5) begin errors++; $display("FAIL rw_same_old: got %0d want %0d", csr_rdata, e); end
      drive(1'b1, 1'b0, 12'hB03, 32'h0, 1'b0, '0);
      e = exp_q.pop_front();
      checks++; if (csr_rdata !== e || e !== 32'd7) begin errors++; $display("FAIL write_wins: got %0d want %0d", csr_rdata, e); end
   endtask

   task automatic test_unmapped();
      logic [31:0] e;
      drive(1'b1, 1'b1, 12'hABC, 32'h1234_5678, 1'b0, '0);
      e = exp_q.pop_front();
      checks++; if (hit_seen !== 1'b0) begin errors++; $display("FAIL unmapped_hit: got %0b want 0", hit_seen); end
      checks++; if (csr_rvalid !== 1'b1) begin errors++; $display("FAIL unmapped_rvalid: got %0b want 1", csr_rvalid); end
      checks++; if (csr_rdata !== e || e !== 32'h0) begin errors++; $display("FAIL unmapped_rdata: got %h want %h", csr_rdata, e); end
      drive(1'b1, 1'b0, 12'h7C0, 32'h0, 1'b0, '0);
      e = exp_q.pop_front();
      checks++; if (hit_seen !== model_hit(12'h7C0)) begin errors++; $display("FAIL ovf_addr_hit: got %0b want %0b", hit_seen, model_hit(12'h7C0)); end
      checks++; if (csr_rdata !== e) begin errors++; $display("FAIL ovf_addr_rdata: got %h want %h", csr_rdata, e); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] e;
      idle(3);
      csr_re = 1'b1; csr_addr = 12'hB00;
      #2 rst = 1'b0;
      #2 csr_re = 1'b0;
      checks++; if (csr_rvalid !== 1'b0) begin errors++; $display("FAIL midreset_rvalid: got %0b want 0", csr_rvalid); end
      model_reset();
      @(negedge clk);
      checks++; if (csr_rvalid !== 1'b0) begin errors++; $display("FAIL midreset_rvalid_held: got %0b want 0", csr_rvalid); end
      checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL midreset_rdata: got %h want 0", csr_rdata); end
      rst = 1'b1;
      drive(1'b1, 1'b0, 12'hB00, 32'h0, 1'b0, '0);
      e = exp_q.pop_front();
      checks++; if (csr_rdata !== e || e !== 32'h0) begin errors++; $display("FAIL midreset_mcycle: got %h want %h", csr_rdata, e); end
      drive(1'b1, 1'b0, 12'hB03, 32'h0, 1'b0, '0);
      e = exp_q.pop_front();
      checks++; if (csr_rdata !== e || e !== 32'h0) begin errors++; $display("FAIL midreset_hpm3: got %h want %h", csr_rdata, e); end
   endtask

`ifdef PERF_OVF_IRQ_EN
   task automatic test_ovf_irq();
      logic [31:0] e;
      drive(1'b0, 1'b1, 12'h7C0, 32'hFFFF_FFFF, 1'b0, '0);
      drive(1'b0, 1'b1, 12'hB83, 32'hFFFF_FFFF, 1'b0, '0);
      drive(1'b0, 1'b1, 12'hB03, 32'hFFFF_FFFF, 1'b0, '0);
      drive(1'b0, 1'b1, 12'h7C1, 32'h8, 1'b0, '0);
      checks++; if (ovf_irq !== 1'b0) begin errors++; $display("FAIL irq_before_wrap: got %0b want 0", ovf_irq); end
      drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 4'b0001);
      idle(1);
      checks++; if (ovf_irq !== irq_m || irq_m !== 1'b1) begin errors++; $display("FAIL irq_on_wrap: got %0b want %0b", ovf_irq, irq_m); end
      drive(1'b1, 1'b0, 12'h7C0, 32'h0, 1'b0, '0);
      e = exp_q.pop_front();
      checks++; if (csr_rdata !== e || e !== 32'h8) begin errors++; $display("FAIL ovf_status: got %h want %h", csr_rdata, e); end
      drive(1'b0, 1'b1, 12'h7C0, 32'h8, 1'b0, '0);
      idle(1);
      checks++; if (ovf_irq !== irq_m || irq_m !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %0b want %0b", ovf_irq, irq_m); end
   endtask
`endif

   task automatic test_random();
      logic [11:0] addrs [18];
      logic [31:0] wvals [4];
      logic [31:0] e;
      logic [11:0] a;
      logic        re, we;
      addrs = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06, 12'hB80, 12'hB82, 12'hB83,
                12'hB84, 12'hB85, 12'hB86, 12'h320, 12'h7C0, 12'h7C1, 12'hABC, 12'hB01, 12'hB07};
      wvals = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 32'h0};
      for (int c = 0; c < 300; c++) begin
         a  = addrs[$urandom_range(0, 17)];
         re = 1'($urandom_range(0, 1));
         we = ($urandom_range(0, 2) == 0);
         wvals[3] = $urandom;
         if (a == 12'h320) wvals[2] = $urandom_range(0, 3) == 0 ? $urandom : 32'h0;
         else wvals[2] = 32'h0;
         drive(re, we, a, wvals[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), NUM_HPM'($urandom));
         checks++; if (hit_seen !== model_hit(a)) begin errors++; $display("FAIL rnd_hit c%0d a=%h: got %0b want %0b", c, a, hit_seen, model_hit(a)); end
         checks++; if (csr_rvalid !== exp_rvalid) begin errors++; $display("FAIL rnd_rvalid c%0d: got %0b want %0b", c, csr_rvalid, exp_rvalid); end
         if (exp_rvalid) e = exp_q.pop_front();
         else e = last_rdata;
         checks++; if (csr_rdata !== e) begin errors++; $display("FAIL rnd_rdata c%0d a=%h: got %h want %h", c, a, csr_rdata, e); end
         checks++; if (ovf_irq !== irq_m) begin errors++; $display("FAIL rnd_irq c%0d: got %0b want %0b", c, ovf_irq, irq_m); end
      end
   endtask

   initial begin
      impl_m = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
      test_reset();
      test_mcycle();
      test_instret_carry();
      test_inhibit();
      test_write_priority();
      test_unmapped();
      test_reset_mid();
`ifdef PERF_OVF_IRQ_EN
      test_ovf_irq();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
